// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the instruction-memory word
// address, captures the returned word into IF/ID, handles stall/flush/redirect,
// traps bad fetch targets in FAULT and counts delivered instructions.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic        ifid_valid,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_pc_plus4,
  output logic [31:0] ifid_instr,
  output logic        fetch_fault,
  output logic [31:0] fetch_count
);

  localparam int unsigned AW  = $clog2(IMEM_WORDS);
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic [31:0] ifid_pc_q, ifid_pc_d;
  logic [31:0] ifid_pc_plus4_q, ifid_pc_plus4_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic        fetch_fault_q, fetch_fault_d;
  logic [31:0] fetch_count_q, fetch_count_d;

  // A fetch target is usable when word aligned and inside the memory.
  function automatic logic target_ok(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a[31:AW+2] == '0);
  endfunction

  // Word index into instruction memory, straight from the PC.
  assign imem_addr = 32'(pc_q[AW+1:2]);

  // Next-state and IF/ID load decisions.
  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    ifid_valid_d    = ifid_valid_q;
    ifid_pc_d       = ifid_pc_q;
    ifid_pc_plus4_d = ifid_pc_plus4_q;
    ifid_instr_d    = ifid_instr_q;
    fetch_fault_d   = fetch_fault_q;
    fetch_count_d   = fetch_count_q;

    unique case (state_q)
      ST_BOOT: begin
        state_d = ST_RUN;
      end

      ST_RUN: begin
        if (redirect_valid) begin
          // Taken branch/jump wins over stall and flush; one bubble.
          pc_d         = redirect_pc;
          ifid_valid_d = 1'b0;
          ifid_instr_d = NOP;
        end else if (stall) begin
          if (flush) begin
            ifid_valid_d = 1'b0;
            ifid_instr_d = NOP;
          end
        end else if (!target_ok(pc_q)) begin
          // Bad target: capture nothing, park the PC.
          state_d       = ST_FAULT;
          fetch_fault_d = 1'b1;
          ifid_valid_d  = 1'b0;
          ifid_instr_d  = NOP;
        end else begin
          ifid_pc_d       = pc_q;
          ifid_pc_plus4_d = pc_q + 32'd4;
          ifid_valid_d    = !flush;
          ifid_instr_d    = flush ? NOP : imem_instr;
          pc_d            = pc_q + 32'd4;
          if (!flush) begin
            fetch_count_d = fetch_count_q + 32'd1;
          end
        end
      end

      ST_FAULT: begin
        ifid_valid_d = 1'b0;
        ifid_instr_d = NOP;
        // Only a usable redirect target gets us out.
        if (redirect_valid && target_ok(redirect_pc)) begin
          pc_d          = redirect_pc;
          state_d       = ST_RUN;
          fetch_fault_d = 1'b0;
        end
      end

      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  // State and pipeline registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= ST_BOOT;
      pc_q            <= RESET_PC;
      ifid_valid_q    <= 1'b0;
      ifid_pc_q       <= 32'h0;
      ifid_pc_plus4_q <= 32'h0;
      ifid_instr_q    <= NOP;
      fetch_fault_q   <= 1'b0;
      fetch_count_q   <= 32'h0;
    end else begin
      state_q         <= state_d;
      pc_q            <= pc_d;
      ifid_valid_q    <= ifid_valid_d;
      ifid_pc_q       <= ifid_pc_d;
      ifid_pc_plus4_q <= ifid_pc_plus4_d;
      ifid_instr_q    <= ifid_instr_d;
      fetch_fault_q   <= fetch_fault_d;
      fetch_count_q   <= fetch_count_d;
    end
  end

  assign ifid_valid    = ifid_valid_q;
  assign ifid_pc       = ifid_pc_q;
  assign ifid_pc_plus4 = ifid_pc_plus4_q;
  assign ifid_instr    = ifid_instr_q;
  assign fetch_fault   = fetch_fault_q;
  assign fetch_count   = fetch_count_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed scenarios plus a randomized
// run against a rule-level reference model of the fetch stage.
module tb_if_fetch_unit;

  localparam int unsigned WORDS = 256;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, flush, redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr, imem_instr;
  logic        ifid_valid, fetch_fault;
  logic [31:0] ifid_pc, ifid_pc_plus4, ifid_instr, fetch_count;

  logic [31:0] mem [WORDS];

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  bit          m_booting, m_faulted, m_valid;
  logic [31:0] m_pc, m_ipc, m_ipc4, m_instr, m_count;

  if_fetch_unit #(.RESET_PC(32'h0), .IMEM_WORDS(WORDS)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_addr(imem_addr), .imem_instr(imem_instr),
    .ifid_valid(ifid_valid), .ifid_pc(ifid_pc), .ifid_pc_plus4(ifid_pc_plus4),
    .ifid_instr(ifid_instr), .fetch_fault(fetch_fault), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  assign imem_instr = (imem_addr < WORDS) ? mem[imem_addr[7:0]] : 32'hDEAD_BEEF;

  function automatic bit good(input logic [31:0] a);
    return (a < 4 * WORDS) && (a % 4 == 0);
  endfunction

  task automatic m_reset();
    m_booting = 1; m_faulted = 0; m_valid = 0;
    m_pc = 0; m_ipc = 0; m_ipc4 = 0; m_instr = NOP; m_count = 0;
  endtask

  // One clock edge as the fetch rules describe it.
  task automatic m_edge();
    if (m_booting) begin
      m_booting = 0;
    end else if (m_faulted) begin
      m_valid = 0; m_instr = NOP;
      if (redirect_valid && good(redirect_pc)) begin
        m_pc = redirect_pc; m_faulted = 0;
      end
    end else if (redirect_valid) begin
      m_pc = redirect_pc; m_valid = 0; m_instr = NOP;
    end else if (stall) begin
      if (flush) begin m_valid = 0; m_instr = NOP; end
    end else if (!good(m_pc)) begin
      m_faulted = 1; m_valid = 0; m_instr = NOP;
    end else begin
      m_ipc = m_pc; m_ipc4 = m_pc + 4;
      m_valid = !flush;
      m_instr = flush ? NOP : mem[m_pc / 4];
      if (!flush) m_count = m_count + 1;
      m_pc = m_pc + 4;
    end
  endtask

  task automatic step();
    m_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stall = 0; flush = 0; redirect_valid = 0; redirect_pc = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    @(negedge clk);
    rst = 1; m_reset();
    #2;
    rst = 0;
    @(posedge clk); #1;
    // first edge after release handled below by caller via step()
  endtask

  // Reset leaves state but first edge after release was consumed above;
  // replay it in the model.
  task automatic reset_and_boot();
    do_reset();
    m_edge();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1; m_reset();
    #3;
    n_vec++; if (ifid_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %0b want 0", ifid_valid); end
    n_vec++; if (ifid_instr !== NOP) begin n_err++; $display("FAIL reset_instr got %h want %h", ifid_instr, NOP); end
    n_vec++; if (ifid_pc !== 0 || ifid_pc_plus4 !== 0) begin n_err++; $display("FAIL reset_pc got %h/%h want 0/0", ifid_pc, ifid_pc_plus4); end
    n_vec++; if (fetch_fault !== 0 || fetch_count !== 0) begin n_err++; $display("FAIL reset_fault_count got %b/%0d want 0/0", fetch_fault, fetch_count); end
    n_vec++; if (imem_addr !== 0) begin n_err++; $display("FAIL reset_imem_addr got %h want 0", imem_addr); end
  endtask

  task automatic test_stream();
    logic [31:0] exp_i [4];
    exp_i[0] = 32'h00200513; exp_i[1] = 32'h00100113;
    exp_i[2] = 32'h00250233; exp_i[3] = 32'h00412223;
    reset_and_boot();
    n_vec++; if (ifid_valid !== 1'b0) begin n_err++; $display("FAIL stream_edge1_valid got %b want 0", ifid_valid); end
    for (int k = 0; k < 4; k++) begin
      step();
      n_vec++;
      if (ifid_valid !== 1 || ifid_pc !== 32'(4 * k) || ifid_instr !== exp_i[k] || ifid_pc_plus4 !== 32'(4 * k + 4)) begin
        n_err++;
        $display("FAIL stream_cap%0d got v=%b pc=%h pc4=%h i=%h want v=1 pc=%h i=%h", k, ifid_valid, ifid_pc, ifid_pc_plus4, ifid_instr, 4 * k, exp_i[k]);
      end
    end
    n_vec++; if (fetch_count !== 4) begin n_err++; $display("FAIL stream_count got %0d want 4", fetch_count); end
  endtask

  task automatic test_stall();
    reset_and_boot();
    step(); step();
    stall = 1;
    for (int k = 0; k < 3; k++) begin
      step();
      n_vec++;
      if (ifid_pc !== 32'h4 || ifid_instr !== 32'h00100113 || imem_addr !== 2 || ifid_valid !== 1) begin
        n_err++;
        $display("FAIL stall_hold%0d got pc=%h i=%h a=%h v=%b want pc=4 i=00100113 a=2 v=1", k, ifid_pc, ifid_instr, imem_addr, ifid_valid);
      end
    end
    stall = 0;
    step();
    n_vec++; if (ifid_pc !== 32'h8 || ifid_valid !== 1) begin n_err++; $display("FAIL stall_resume got pc=%h v=%b want 8/1", ifid_pc, ifid_valid); end
  endtask

  task automatic test_redirect_stall();
    stall = 1; redirect_valid = 1; redirect_pc = 32'h20;
    step();
    n_vec++;
    if (ifid_valid !== 0 || ifid_instr !== NOP || imem_addr !== 8) begin
      n_err++;
      $display("FAIL redir_bubble got v=%b i=%h a=%h want 0/%h/8", ifid_valid, ifid_instr, imem_addr, NOP);
    end
    idle_inputs();
    step();
    n_vec++; if (ifid_pc !== 32'h20 || ifid_valid !== 1 || ifid_instr !== mem[8]) begin n_err++; $display("FAIL redir_target got pc=%h v=%b i=%h want 20/1/%h", ifid_pc, ifid_valid, ifid_instr, mem[8]); end
  endtask

  task automatic test_flush();
    reset_and_boot();
    step(); step();
    flush = 1;
    step();
    flush = 0;
    n_vec++;
    if (ifid_valid !== 0 || ifid_instr !== NOP || imem_addr !== 3 || fetch_count !== 2) begin
      n_err++;
      $display("FAIL flush got v=%b i=%h a=%h cnt=%0d want 0/%h/3/2", ifid_valid, ifid_instr, imem_addr, fetch_count, NOP);
    end
  endtask

  task automatic test_fault();
    redirect_valid = 1; redirect_pc = 32'h400;
    step();
    idle_inputs();
    n_vec++; if (fetch_fault !== 0) begin n_err++; $display("FAIL fault_early got %b want 0", fetch_fault); end
    step();
    n_vec++; if (fetch_fault !== 1 || ifid_valid !== 0) begin n_err++; $display("FAIL fault_enter got f=%b v=%b want 1/0", fetch_fault, ifid_valid); end
    redirect_valid = 1; redirect_pc = 32'h402;
    step();
    idle_inputs();
    step();
    n_vec++; if (fetch_fault !== 1 || ifid_valid !== 0) begin n_err++; $display("FAIL fault_bad_redir got f=%b v=%b want 1/0", fetch_fault, ifid_valid); end
    redirect_valid = 1; redirect_pc = 32'h10;
    step();
    idle_inputs();
    n_vec++; if (fetch_fault !== 0 || imem_addr !== 4) begin n_err++; $display("FAIL fault_leave got f=%b a=%h want 0/4", fetch_fault, imem_addr); end
    step();
    n_vec++; if (ifid_pc !== 32'h10 || ifid_valid !== 1) begin n_err++; $display("FAIL fault_recover got pc=%h v=%b want 10/1", ifid_pc, ifid_valid); end
  endtask

  task automatic test_async_reset();
    redirect_valid = 1; redirect_pc = 32'h18;
    step();
    idle_inputs();
    n_vec++; if (imem_addr !== 6) begin n_err++; $display("FAIL areset_setup got a=%h want 6", imem_addr); end
    step();
    #2;
    rst = 1; m_reset();
    #1;
    n_vec++;
    if (ifid_valid !== 0 || ifid_pc !== 0 || ifid_pc_plus4 !== 0 || ifid_instr !== NOP ||
        fetch_fault !== 0 || fetch_count !== 0 || imem_addr !== 0) begin
      n_err++;
      $display("FAIL areset got v=%b pc=%h i=%h f=%b cnt=%0d a=%h want reset values", ifid_valid, ifid_pc, ifid_instr, fetch_fault, fetch_count, imem_addr);
    end
    #2;
    rst = 0;
  endtask

  task automatic test_random();
    int r;
    reset_and_boot();
    for (int k = 0; k < 400; k++) begin
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 6) == 0);
      redirect_valid = ($urandom_range(0, 9) == 0);
      r = $urandom_range(0, 19);
      if (r < 14)      redirect_pc = 32'($urandom_range(0, WORDS - 1)) * 4;
      else if (r < 16) redirect_pc = 32'($urandom_range(0, WORDS - 1)) * 4 + 32'($urandom_range(1, 3));
      else if (r < 18) redirect_pc = 32'h400 + 32'($urandom_range(0, 64)) * 4;
      else             redirect_pc = 32'hFFFF_FFF8;
      step();
      n_vec++;
      if (ifid_valid !== m_valid || ifid_pc !== m_ipc || ifid_pc_plus4 !== m_ipc4 ||
          ifid_instr !== m_instr || fetch_fault !== m_faulted || fetch_count !== m_count ||
          imem_addr !== 32'((m_pc / 4) % WORDS)) begin
        n_err++;
        $display("FAIL rand%0d got v=%b pc=%h pc4=%h i=%h f=%b c=%0d a=%h want v=%b pc=%h pc4=%h i=%h f=%b c=%0d a=%h",
                 k, ifid_valid, ifid_pc, ifid_pc_plus4, ifid_instr, fetch_fault, fetch_count, imem_addr,
                 m_valid, m_ipc, m_ipc4, m_instr, m_faulted, m_count, (m_pc / 4) % WORDS);
      end
    end
    idle_inputs();
  endtask

  initial begin
    for (int i = 0; i < WORDS; i++) mem[i] = $urandom;
    mem[0] = 32'h00200513; mem[1] = 32'h00100113;
    mem[2] = 32'h00250233; mem[3] = 32'h00412223;
    test_reset();
    test_stream();
    test_stall();
    test_redirect_stall();
    test_flush();
    test_fault();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction-fetch stage of the RV32I pipeline. It owns the program counter and drives the word address of the combinational instruction memory. It captures the returned instruction into the IF/ID pipeline register for decode. It handles stall, flush and branch/jump redirect, flags out-of-range or misaligned fetch targets, and counts delivered instructions.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `IMEM_WORDS`, default 256: instruction-memory depth in 32-bit words; must be a power of two.
- `clk`  in  1: clock; all state updates on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `stall`  in  1: hold PC and IF/ID contents (load-use hazard from decode).
- `flush`  in  1: squash the instruction being captured into IF/ID.
- `redirect_valid`  in  1: taken branch/jump from execute.
- `redirect_pc`  in  32: redirect target byte address.
- `imem_addr`  out  32: word index to instruction memory, {zero-extended, pc[log2(IMEM_WORDS)+1:2]}.
- `imem_instr`  in  32: instruction word returned combinationally for `imem_addr`.
- `ifid_valid`  out  1: IF/ID holds a real instruction.
- `ifid_pc`  out  32: byte PC of the IF/ID instruction.
- `ifid_pc_plus4`  out  32: `ifid_pc + 4`.
- `ifid_instr`  out  32: captured instruction; 32'h0000_0013 (NOP) when invalid.
- `fetch_fault`  out  1: fetch unit is in FAULT.
- `fetch_count`  out  32: number of instructions delivered into IF/ID.

## Operation
- The internal register `pc` is the byte address of the next fetch. `imem_addr` is a pure combinational function of `pc`.
- A PC is in range when `pc < 4*IMEM_WORDS`. It is aligned when `pc[1:0]==0`.
- State machine with states BOOT, RUN and FAULT.
  - **BOOT:** entered on reset. Lasts exactly one cycle, then goes to RUN unconditionally. No capture happens in BOOT; IF/ID stays invalid. `redirect_valid` is ignored in BOOT.
  - **RUN:** per-edge priority is redirect > stall > normal.
    - Redirect: `pc <= redirect_pc`; IF/ID is loaded as invalid (NOP, `ifid_valid=0`). Redirect overrides `stall` and `flush`.
    - Stall, no redirect: `pc` and all IF/ID outputs hold. A concurrent `flush` still clears `ifid_valid` and forces NOP.
    - Normal: capture `ifid_instr<=imem_instr`, `ifid_pc<=pc`, `ifid_pc_plus4<=pc+4`, `ifid_valid<=!flush`, then `pc<=pc+4`. When flushed, `ifid_instr` loads NOP.
    - RUN goes to FAULT when the current `pc` is out of range or misaligned at a normal (non-stall, non-redirect) edge. That edge captures nothing (IF/ID loaded invalid) and `pc` holds.
    - A redirect to a bad target is accepted. The fault is then detected on the following edge.
  - **FAULT:** `fetch_fault=1`; `pc` holds; IF/ID held invalid/NOP; `stall` and `flush` are ignored.
    - A `redirect_valid` with an aligned, in-range target loads `pc` and returns to RUN.
    - A `redirect_valid` with a bad target is ignored.
- `fetch_count` increments by 1 on every edge that loads `ifid_valid=1`. It wraps from 32'hFFFF_FFFF to 0.
- `pc+4` wraps modulo 2^32. A wrapped PC is out of range and causes FAULT.

## Timing
- Reset values (asynchronous, while `rst=1`):
  - state BOOT, `pc=RESET_PC`, `ifid_valid=0`
  - `ifid_pc=0`, `ifid_pc_plus4=0`, `ifid_instr=32'h0000_0013`
  - `fetch_fault=0`, `fetch_count=0`
- `imem_addr` reflects `RESET_PC` immediately during reset.
- Reset asserted mid-operation aborts everything at once, including FAULT.
- Latency: the instruction at `pc` appears on `ifid_*` one edge after it is presented on `imem_addr`.
- Throughput: one instruction per cycle in RUN without stall.
- After reset release:
  - First rising edge: BOOT→RUN.
  - Second edge: first capture, word at `RESET_PC`.
- Redirect penalty: the redirect edge inserts one bubble. The target instruction is valid in IF/ID after the next edge.
- `fetch_fault` is a registered output. It rises on the edge that enters FAULT and falls on the edge that leaves it.

## Test plan
- **Reset and stream.** Memory words 0..3 = 00200513, 00100113, 00250233, 00412223; release reset, run 5 edges. Required: edge 1 has `ifid_valid=0`. Edges 2–5 capture `ifid_pc` 0, 4, 8, 12 with matching instructions. `fetch_count=4`.
- **Stall.** Assert `stall` for 3 cycles after `ifid_pc=4` is captured. Required: `ifid_pc=4`, `ifid_instr=00100113` and `imem_addr=2` all hold for 3 edges; the next edge captures `ifid_pc=8`.
- **Redirect during stall.** `stall=1`, `redirect_valid=1`, `redirect_pc=32'h20`. Required: the next edge gives `ifid_valid=0` and NOP, `imem_addr=8`; the following edge gives `ifid_pc=32'h20`.
- **Flush only.** `flush=1` for one normal edge at `pc=8`. Required: `ifid_valid=0`, `ifid_instr=00000013`, `pc` advances to 12, `fetch_count` unchanged.
- **Fault and recovery.**
  - Redirect to 32'h400 with `IMEM_WORDS=256`. Required: one edge later `fetch_fault=1`.
  - In FAULT, redirect to 32'h402. Required: ignored.
  - Then redirect to 32'h10. Required: `fetch_fault=0` and `ifid_pc=32'h10` two edges later.
- **Async reset mid-stream.** Assert `rst` between edges at `pc=32'h18`. Required: outputs reach reset values without a clock edge, and `imem_addr=0`.
